ysyx_25060170_ifu_fetch: RTL and testbench

Instruction fetch unit for the NPC core. It owns the architectural PC, issues one-at-a-time read requests to instruction memory over a valid/ready request channel and a valid-only response channel, then presents {pc, inst} to the decoder with a valid/ready handshake. It is the producer side of the decoder's pc_i/inst_i inputs. It accepts jump redirects (jump_en plus target) from the writeback stage.

---
 rtl/ysyx_25060170_ifu_fetch_pkg.sv | 22 ++
 rtl/ysyx_25060170_ifu_fetch_if.sv | 31 +++
 rtl/ysyx_25060170_ifu_fetch.sv | 100 ++++++++++
 tb/tb_ysyx_25060170_ifu_fetch.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25060170_ifu_fetch_pkg.sv
// Shared types and constants for the NPC instruction fetch unit.
// Holds the FSM encoding, reset/NOP constants and the sequential PC step.
package ysyx_25060170_pkg;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StReq  = 3'd1,
      StWait = 3'd2,
      StHold = 3'd3,
      StErr  = 3'd4
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [31:0] PC_INC           = 32'd4;

   // Sequential PC step; wraps modulo 2^32.
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + PC_INC;
   endfunction

endpackage

// File: rtl/ysyx_25060170_ifu_fetch_if.sv
// Fetch-unit bundle: imem request/response, decoder handshake and redirect.
// The master modport is the fetch unit; the slave modport is its environment.
interface ysyx_25060170_ifu_fetch_if;

   logic        imem_req_valid_o;
   logic        imem_req_ready_i;
   logic [31:0] imem_req_addr_o;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;
   logic        imem_rsp_err_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        fetch_err_o;

   modport master (
      output imem_req_valid_o, imem_req_addr_o, inst_valid_o, pc_o, inst_o, fetch_err_o,
      input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
      input  inst_ready_i, redirect_i, redirect_pc_i
   );

   modport slave (
      input  imem_req_valid_o, imem_req_addr_o, inst_valid_o, pc_o, inst_o, fetch_err_o,
      output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
      output inst_ready_i, redirect_i, redirect_pc_i
   );

endinterface

// File: rtl/ysyx_25060170_ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one imem read at a time and
// hands {pc, inst} to the decoder; jump redirects come from writeback.
module ysyx_25060170_ifu_fetch
   import ysyx_25060170_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned XLEN     = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   ysyx_25060170_ifu_fetch_if.master         bus
);

   fetch_state_e    r_state, w_state_nxt;
   logic [XLEN-1:0] r_pc, w_pc_nxt;
   logic [31:0]     r_inst, w_inst_nxt;
   logic            r_kill, w_kill_nxt;
   logic            r_err, w_err_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
         r_pc    <= RESET_PC;
         r_inst  <= NOP_INST;
         r_kill  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_inst  <= w_inst_nxt;
         r_kill  <= w_kill_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_inst_nxt  = r_inst;
      w_kill_nxt  = r_kill;
      w_err_nxt   = r_err;

      unique case (r_state)
         StIdle: w_state_nxt = StReq;
         StReq: begin
            if (bus.imem_req_ready_i) w_state_nxt = StWait;
         end
         StWait: begin
            if (bus.imem_rsp_valid_i) begin
               if (r_kill) begin
                  w_kill_nxt  = 1'b0;
                  w_state_nxt = StReq;
               end else if (bus.imem_rsp_err_i) begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = StErr;
               end else begin
                  w_inst_nxt  = bus.imem_rsp_data_i;
                  w_state_nxt = StHold;
               end
            end
         end
         StHold: begin
            if (bus.inst_ready_i) begin
               w_pc_nxt    = pc_inc(r_pc);
               w_state_nxt = StReq;
            end
         end
         StErr: w_state_nxt = StErr;
         default: w_state_nxt = StIdle;
      endcase

      // Redirect overrides the normal step; any same-cycle response is dropped.
      if (bus.redirect_i && (r_state != StErr)) begin
         w_inst_nxt = r_inst;
         w_kill_nxt = 1'b0;
         if (bus.redirect_pc_i[1:0] != 2'b00) begin
            w_pc_nxt    = r_pc;
            w_err_nxt   = 1'b1;
            w_state_nxt = StErr;
         end else begin
            w_pc_nxt    = bus.redirect_pc_i;
            w_state_nxt = StReq;
            // A request in flight to the old PC must have its response discarded.
            if ((r_state == StReq && bus.imem_req_ready_i) ||
                (r_state == StWait && !bus.imem_rsp_valid_i)) begin
               w_state_nxt = StWait;
               w_kill_nxt  = 1'b1;
            end
         end
      end
   end

   assign bus.imem_req_valid_o = (r_state == StReq);
   assign bus.imem_req_addr_o  = r_pc;
   assign bus.inst_valid_o     = (r_state == StHold);
   assign bus.pc_o             = r_pc;
   assign bus.inst_o           = r_inst;
   assign bus.fetch_err_o      = r_err;

endmodule

// File: tb/tb_ysyx_25060170_ifu_fetch.sv
// Directed bench for the fetch unit: the memory and decoder sides are driven
// cycle by cycle and every output is checked against hand-computed values.
module tb_ysyx_25060170_ifu_fetch;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_fail = 0;

   ysyx_25060170_ifu_fetch_if bus ();

   ysyx_25060170_ifu_fetch #(
      .RESET_PC (32'h8000_0000),
      .XLEN     (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_pc", bus.pc_o, 32'h8000_0000);
      chk("rst_inst", bus.inst_o, 32'h0000_0013);
      chk("rst_ivalid", {31'd0, bus.inst_valid_o}, 32'd0);
      chk("rst_reqvalid", {31'd0, bus.imem_req_valid_o}, 32'd0);
      chk("rst_err", {31'd0, bus.fetch_err_o}, 32'd0);
   endtask

   // Entered in REQ; leaves the DUT in HOLD with the instruction presented.
   task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
      chk("req_valid", {31'd0, bus.imem_req_valid_o}, 32'd1);
      chk("req_addr", bus.imem_req_addr_o, addr);
      bus.imem_req_ready_i = 1'b1;
      tick();
      bus.imem_req_ready_i = 1'b0;
      chk("wait_noreq", {31'd0, bus.imem_req_valid_o}, 32'd0);
      chk("wait_novalid", {31'd0, bus.inst_valid_o}, 32'd0);
      bus.imem_rsp_valid_i = 1'b1;
      bus.imem_rsp_data_i  = data;
      tick();
      bus.imem_rsp_valid_i = 1'b0;
      chk("hold_valid", {31'd0, bus.inst_valid_o}, 32'd1);
      chk("hold_inst", bus.inst_o, data);
      chk("hold_pc", bus.pc_o, addr);
   endtask

   initial begin
      bus.imem_req_ready_i = 1'b0;
      bus.imem_rsp_valid_i = 1'b0;
      bus.imem_rsp_data_i  = 32'h0;
      bus.imem_rsp_err_i   = 1'b0;
      bus.inst_ready_i     = 1'b0;
      bus.redirect_i       = 1'b0;
      bus.redirect_pc_i    = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_reset_vals();
      tick();

      // Sequential fetch, decoder always ready.
      bus.inst_ready_i = 1'b1;
      fetch_one(32'h8000_0000, 32'h0000_0093);
      tick();
      chk("seq_1cyc0", {31'd0, bus.inst_valid_o}, 32'd0);
      fetch_one(32'h8000_0004, 32'h0010_0113);
      tick();
      chk("seq_1cyc1", {31'd0, bus.inst_valid_o}, 32'd0);
      fetch_one(32'h8000_0008, 32'h0020_0193);
      tick();
      chk("seq_1cyc2", {31'd0, bus.inst_valid_o}, 32'd0);

      // Decoder backpressure.
      bus.inst_ready_i = 1'b0;
      fetch_one(32'h8000_000C, 32'h0030_0213);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valid", {31'd0, bus.inst_valid_o}, 32'd1);
         chk("bp_pc", bus.pc_o, 32'h8000_000C);
         chk("bp_inst", bus.inst_o, 32'h0030_0213);
         chk("bp_noreq", {31'd0, bus.imem_req_valid_o}, 32'd0);
      end
      bus.inst_ready_i = 1'b1;
      tick();
      bus.inst_ready_i = 1'b0;
      chk("bp_req", {31'd0, bus.imem_req_valid_o}, 32'd1);
      chk("bp_addr", bus.imem_req_addr_o, 32'h8000_0010);

      // Redirect while waiting; the stale response must be discarded.
      bus.imem_req_ready_i = 1'b1;
      tick();
      bus.imem_req_ready_i = 1'b0;
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h8000_0100;
      tick();
      bus.redirect_i = 1'b0;
      chk("rw_pc", bus.pc_o, 32'h8000_0100);
      chk("rw_noreq", {31'd0, bus.imem_req_valid_o}, 32'd0);
      tick();
      chk("rw_novalid", {31'd0, bus.inst_valid_o}, 32'd0);
      bus.imem_rsp_valid_i = 1'b1;
      bus.imem_rsp_data_i  = 32'hDEAD_BEEF;
      tick();
      bus.imem_rsp_valid_i = 1'b0;
      chk("rw_dropvalid", {31'd0, bus.inst_valid_o}, 32'd0);
      chk("rw_dropinst", bus.inst_o, 32'h0030_0213);
      chk("rw_req", {31'd0, bus.imem_req_valid_o}, 32'd1);
      chk("rw_addr", bus.imem_req_addr_o, 32'h8000_0100);

      // Redirect colliding with a decoder accept in HOLD.
      fetch_one(32'h8000_0100, 32'h0040_0293);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h8000_0040;
      bus.inst_ready_i  = 1'b1;
      tick();
      bus.redirect_i   = 1'b0;
      bus.inst_ready_i = 1'b0;
      chk("rh_pc", bus.pc_o, 32'h8000_0040);
      chk("rh_req", {31'd0, bus.imem_req_valid_o}, 32'd1);
      chk("rh_addr", bus.imem_req_addr_o, 32'h8000_0040);
      chk("rh_novalid", {31'd0, bus.inst_valid_o}, 32'd0);

      // PC wrap from the top of the address space.
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'hFFFF_FFFC;
      tick();
      bus.redirect_i = 1'b0;
      fetch_one(32'hFFFF_FFFC, 32'h0050_0313);
      bus.inst_ready_i = 1'b1;
      tick();
      bus.inst_ready_i = 1'b0;
      chk("wrap_pc", bus.pc_o, 32'h0000_0000);
      chk("wrap_req", {31'd0, bus.imem_req_valid_o}, 32'd1);

      // Access fault on a response.
      bus.imem_req_ready_i = 1'b1;
      tick();
      bus.imem_req_ready_i = 1'b0;
      bus.imem_rsp_valid_i = 1'b1;
      bus.imem_rsp_err_i   = 1'b1;
      bus.imem_rsp_data_i  = 32'hDEAD_BEEF;
      tick();
      bus.imem_rsp_valid_i = 1'b0;
      bus.imem_rsp_err_i   = 1'b0;
      chk("ferr_flag", {31'd0, bus.fetch_err_o}, 32'd1);
      chk("ferr_novalid", {31'd0, bus.inst_valid_o}, 32'd0);
      chk("ferr_inst", bus.inst_o, 32'h0050_0313);
      bus.imem_req_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ferr_noreq", {31'd0, bus.imem_req_valid_o}, 32'd0);
         chk("ferr_sticky", {31'd0, bus.fetch_err_o}, 32'd1);
      end
      bus.imem_req_ready_i = 1'b0;

      // Reset out of ERR, then reset again in the middle of WAIT.
      rst = 1'b1;
      #1;
      chk_reset_vals();
      tick();
      rst = 1'b0;
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h8000_0200;
      tick();
      bus.redirect_i = 1'b0;
      chk("rs_addr", bus.imem_req_addr_o, 32'h8000_0200);
      bus.imem_req_ready_i = 1'b1;
      tick();
      bus.imem_req_ready_i = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk_reset_vals();
      tick();
      rst = 1'b0;
      bus.imem_rsp_valid_i = 1'b1;
      bus.imem_rsp_data_i  = 32'hDEAD_BEEF;
      tick();
      bus.imem_rsp_valid_i = 1'b0;
      chk("rs_ignore_inst", bus.inst_o, 32'h0000_0013);
      chk("rs_ignore_valid", {31'd0, bus.inst_valid_o}, 32'd0);
      fetch_one(32'h8000_0000, 32'h0000_0093);

      // Misaligned redirect target.
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h8000_0002;
      tick();
      bus.redirect_i = 1'b0;
      chk("mis_err", {31'd0, bus.fetch_err_o}, 32'd1);
      chk("mis_pc", bus.pc_o, 32'h8000_0000);
      chk("mis_novalid", {31'd0, bus.inst_valid_o}, 32'd0);
      bus.imem_req_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mis_noreq", {31'd0, bus.imem_req_valid_o}, 32'd0);
      end
      bus.imem_req_ready_i = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
